id_exe_stage_reg: RTL and testbench

- Pipeline register between the ID stage and the EXE stage of the 5-stage MIPS pipeline.
- Captures decoded ID fields each cycle. Inserts a bubble when the hazard detection unit asserts hazard_detected. Clears on branch flush. Holds everything on global freeze.
- Feeds dest_EXE, WB_EN_EXE and MEM_R_EN_EXE back to the hazard detection unit, and src1/src2 to the forwarding unit.
- Keeps saturating bubble/flush event counters for performance debug.

---
 rtl/id_exe_stage_reg_pkg.sv | 39 +++
 rtl/id_exe_stage_reg_if.sv | 52 +++++
 rtl/id_exe_stage_reg_pipe_reg.sv | 34 +++
 rtl/id_exe_stage_reg.sv | 92 +++++++++
 tb/tb_id_exe_stage_reg.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/id_exe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_stage_reg_pkg
// Description : Shared widths, opcodes and branch codes for the ID/EXE
//               pipeline register, plus its per-edge action decode.
// Revision    : 1.0 - initial release
// ============================================================================
package id_exe_stage_reg_pkg;

    localparam int c_WORD_LEN    = 32;
    localparam int c_EXE_CMD_LEN = 4;
    localparam int c_REG_IDX_LEN = 5;
    localparam int c_BRANCH_LEN  = 2;

    localparam logic [c_EXE_CMD_LEN-1:0] c_EXE_NO_OPERATION = 4'd0;

    localparam logic [c_BRANCH_LEN-1:0] c_COND_NONE = 2'd0;
    localparam logic [c_BRANCH_LEN-1:0] c_COND_BEZ  = 2'd1;
    localparam logic [c_BRANCH_LEN-1:0] c_COND_BNE  = 2'd2;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_HOLD   = 2'd3
    } stage_act_e;

    // Freeze beats flush, flush beats a hazard bubble.
    function automatic stage_act_e stage_action(input logic freeze,
                                                input logic flush,
                                                input logic hazard);
        if (freeze) return ACT_HOLD;
        if (flush)  return ACT_FLUSH;
        if (hazard) return ACT_BUBBLE;
        return ACT_LOAD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_exe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_stage_reg_if
// Description : ID-side fields, pipeline control and EXE-side registered
//               fields of the ID/EXE pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_exe_stage_reg_if
    import id_exe_stage_reg_pkg::*;
#(
    parameter int WORD_LEN    = c_WORD_LEN,
    parameter int EXE_CMD_LEN = c_EXE_CMD_LEN,
    parameter int CNT_LEN     = 16
);
    logic                   freeze;
    logic                   flush;
    logic                   hazard_detected;

    logic [WORD_LEN-1:0]    PC_in, val1_in, val2_in, imm_in;
    logic [4:0]             src1_in, src2_in, dest_in;
    logic [EXE_CMD_LEN-1:0] EXE_CMD_in;
    logic                   MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, is_imm_in, ST_or_BNE_in;
    logic [1:0]             branch_comm_in;

    logic [WORD_LEN-1:0]    PC_out, val1_out, val2_out, imm_out;
    logic [4:0]             src1_out, src2_out, dest_EXE;
    logic [EXE_CMD_LEN-1:0] EXE_CMD_out;
    logic                   MEM_R_EN_EXE, MEM_W_EN_EXE, WB_EN_EXE, is_imm_out, ST_or_BNE_out;
    logic [1:0]             branch_comm_out;
    logic [CNT_LEN-1:0]     bubble_cnt, flush_cnt;

    modport master (
        output freeze, flush, hazard_detected,
        output PC_in, val1_in, val2_in, imm_in, src1_in, src2_in, dest_in,
        output EXE_CMD_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, is_imm_in,
        output ST_or_BNE_in, branch_comm_in,
        input  PC_out, val1_out, val2_out, imm_out, src1_out, src2_out, dest_EXE,
        input  EXE_CMD_out, MEM_R_EN_EXE, MEM_W_EN_EXE, WB_EN_EXE, is_imm_out,
        input  ST_or_BNE_out, branch_comm_out, bubble_cnt, flush_cnt
    );

    modport slave (
        input  freeze, flush, hazard_detected,
        input  PC_in, val1_in, val2_in, imm_in, src1_in, src2_in, dest_in,
        input  EXE_CMD_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, is_imm_in,
        input  ST_or_BNE_in, branch_comm_in,
        output PC_out, val1_out, val2_out, imm_out, src1_out, src2_out, dest_EXE,
        output EXE_CMD_out, MEM_R_EN_EXE, MEM_W_EN_EXE, WB_EN_EXE, is_imm_out,
        output ST_or_BNE_out, branch_comm_out, bubble_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_exe_stage_reg_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : Parameterised pipeline register with synchronous active-low
//               reset, load enable and synchronous clear to CLR_VALUE.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic             clr,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_q;

    // Clear only takes effect when enabled, so a stall also holds a pending clear off.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (en) begin
            if (clr) r_q <= CLR_VALUE;
            else     r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_stage_reg
// Description : ID/EXE pipeline register with bubble insertion, branch flush,
//               global freeze and saturating bubble/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module id_exe_stage_reg
    import id_exe_stage_reg_pkg::*;
#(
    parameter int WORD_LEN    = c_WORD_LEN,
    parameter int EXE_CMD_LEN = c_EXE_CMD_LEN,
    parameter int CNT_LEN     = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    id_exe_stage_reg_if.slave  bus
);
    localparam int c_CTRL_W = 3*c_REG_IDX_LEN + EXE_CMD_LEN + c_BRANCH_LEN + 5;
    localparam int c_DATA_W = 4*WORD_LEN;

    // Indices are cleared with the control bits so a bubble never looks like an EXE hazard.
    localparam logic [c_CTRL_W-1:0] c_CTRL_CLR = {
        {(3*c_REG_IDX_LEN){1'b0}},
        EXE_CMD_LEN'(c_EXE_NO_OPERATION),
        c_COND_NONE,
        5'b0
    };
    localparam logic [CNT_LEN-1:0] c_CNT_MAX = {CNT_LEN{1'b1}};

    logic [c_CTRL_W-1:0] w_ctrl_d, w_ctrl_q;
    logic [c_DATA_W-1:0] w_data_d, w_data_q;
    logic                w_en, w_clr;
    stage_act_e          w_act;
    logic [CNT_LEN-1:0]  r_bubble_cnt, r_flush_cnt;

    assign w_en  = ~bus.freeze;
    assign w_clr = bus.flush | bus.hazard_detected;
    assign w_act = stage_action(bus.freeze, bus.flush, bus.hazard_detected);

    assign w_ctrl_d = {bus.src1_in, bus.src2_in, bus.dest_in, bus.EXE_CMD_in,
                       bus.branch_comm_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in,
                       bus.WB_EN_in, bus.is_imm_in, bus.ST_or_BNE_in};
    assign w_data_d = {bus.PC_in, bus.val1_in, bus.val2_in, bus.imm_in};

    pipe_reg #(
        .WIDTH     (c_CTRL_W),
        .CLR_VALUE (c_CTRL_CLR)
    ) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (w_clr),
        .d   (w_ctrl_d),
        .q   (w_ctrl_q)
    );

    pipe_reg #(
        .WIDTH     (c_DATA_W),
        .CLR_VALUE ('0)
    ) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (1'b0),
        .d   (w_data_d),
        .q   (w_data_q)
    );

    assign {bus.src1_out, bus.src2_out, bus.dest_EXE, bus.EXE_CMD_out,
            bus.branch_comm_out, bus.MEM_R_EN_EXE, bus.MEM_W_EN_EXE,
            bus.WB_EN_EXE, bus.is_imm_out, bus.ST_or_BNE_out} = w_ctrl_q;
    assign {bus.PC_out, bus.val1_out, bus.val2_out, bus.imm_out} = w_data_q;

    // A combined flush+hazard edge is counted as a flush only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_act == ACT_FLUSH && r_flush_cnt != c_CNT_MAX)
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_act == ACT_BUBBLE && r_bubble_cnt != c_CNT_MAX)
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bus.bubble_cnt = r_bubble_cnt;
    assign bus.flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_exe_stage_reg
// Description : Directed self-checking bench for the ID/EXE pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_exe_stage_reg;
    localparam int WL   = 32;
    localparam int CL   = 4;
    localparam int CNTL = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    id_exe_stage_reg_if #(.WORD_LEN(WL), .EXE_CMD_LEN(CL), .CNT_LEN(CNTL)) bus();

    id_exe_stage_reg #(.WORD_LEN(WL), .EXE_CMD_LEN(CL), .CNT_LEN(CNTL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [31:0] pc, input logic [31:0] v1,
                              input logic [31:0] v2, input logic [31:0] imm,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [3:0] cmd,
                              input logic mr, input logic mw, input logic wb,
                              input logic ii, input logic sb, input logic [1:0] bc);
        bus.PC_in = pc;   bus.val1_in = v1; bus.val2_in = v2; bus.imm_in = imm;
        bus.src1_in = s1; bus.src2_in = s2; bus.dest_in = d;  bus.EXE_CMD_in = cmd;
        bus.MEM_R_EN_in = mr; bus.MEM_W_EN_in = mw; bus.WB_EN_in = wb;
        bus.is_imm_in = ii;   bus.ST_or_BNE_in = sb; bus.branch_comm_in = bc;
    endtask

    function automatic logic [25:0] ctrl_obs();
        return {bus.src1_out, bus.src2_out, bus.dest_EXE, bus.EXE_CMD_out,
                bus.branch_comm_out, bus.MEM_R_EN_EXE, bus.MEM_W_EN_EXE,
                bus.WB_EN_EXE, bus.is_imm_out, bus.ST_or_BNE_out};
    endfunction

    function automatic logic [127:0] data_obs();
        return {bus.PC_out, bus.val1_out, bus.val2_out, bus.imm_out};
    endfunction

    task automatic test_reset();
        drive_load(32'hFFFF_FFF0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                   5'd31, 5'd30, 5'd29, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
        bus.freeze = 1'b1; bus.flush = 1'b1; bus.hazard_detected = 1'b1;
        rst = 1'b0;
        step(); step();
        n_checks++; if (ctrl_obs() !== 26'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", ctrl_obs()); end
        n_checks++; if (data_obs() !== 128'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_obs()); end
        n_checks++; if (bus.bubble_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_bubble_cnt: got %0d expected 0", bus.bubble_cnt); end
        n_checks++; if (bus.flush_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d expected 0", bus.flush_cnt); end
        rst = 1'b1; bus.freeze = 1'b0; bus.flush = 1'b0; bus.hazard_detected = 1'b0;
    endtask

    task automatic test_normal_load();
        drive_load(32'h0000_0040, 32'h0000_1234, 32'h0000_5678, 32'hFFFF_FFFC,
                   5'd3, 5'd4, 5'd5, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        step();
        n_checks++; if (bus.dest_EXE !== 5'd5) begin n_fail++; $display("FAIL load_dest: got %0d expected 5", bus.dest_EXE); end
        n_checks++; if (bus.WB_EN_EXE !== 1'b1) begin n_fail++; $display("FAIL load_wb_en: got %b expected 1", bus.WB_EN_EXE); end
        n_checks++; if (bus.EXE_CMD_out !== 4'h2) begin n_fail++; $display("FAIL load_exe_cmd: got %h expected 2", bus.EXE_CMD_out); end
        n_checks++; if (bus.val1_out !== 32'h0000_1234) begin n_fail++; $display("FAIL load_val1: got %h expected 00001234", bus.val1_out); end
        n_checks++; if (ctrl_obs() !== {5'd3, 5'd4, 5'd5, 4'h2, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1})
            begin n_fail++; $display("FAIL load_ctrl_all: got %h", ctrl_obs()); end
        n_checks++; if (data_obs() !== {32'h0000_0040, 32'h0000_1234, 32'h0000_5678, 32'hFFFF_FFFC})
            begin n_fail++; $display("FAIL load_data_all: got %h", data_obs()); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] pc;
            pc = 32'h0000_0100 + 32'(i * 4);
            drive_load(pc, 32'h0, ~pc, 32'h0, 5'd1, 5'd2, 5'(i + 1), 4'(i),
                       1'b0, 1'b0, i[0], 1'b0, 1'b0, 2'b00);
            step();
            n_checks++; if (bus.PC_out !== pc) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, bus.PC_out, pc); end
            n_checks++; if (bus.val2_out !== ~pc) begin n_fail++; $display("FAIL b2b_val2[%0d]: got %h expected %h", i, bus.val2_out, ~pc); end
            n_checks++; if ({bus.dest_EXE, bus.WB_EN_EXE} !== {5'(i + 1), i[0]})
                begin n_fail++; $display("FAIL b2b_dest_wb[%0d]: got %0d/%b expected %0d/%b", i, bus.dest_EXE, bus.WB_EN_EXE, i + 1, i[0]); end
        end
    endtask

    task automatic test_load_use_bubble();
        drive_load(32'h0000_0200, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_0008,
                   5'd2, 5'd6, 5'd7, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
        bus.hazard_detected = 1'b1;
        step();
        n_checks++; if ({bus.WB_EN_EXE, bus.MEM_R_EN_EXE, bus.MEM_W_EN_EXE} !== 3'b000)
            begin n_fail++; $display("FAIL bubble_wb_mr_mw: got %b expected 000", {bus.WB_EN_EXE, bus.MEM_R_EN_EXE, bus.MEM_W_EN_EXE}); end
        n_checks++; if (bus.dest_EXE !== 5'd0) begin n_fail++; $display("FAIL bubble_dest: got %0d expected 0", bus.dest_EXE); end
        n_checks++; if (ctrl_obs() !== 26'd0) begin n_fail++; $display("FAIL bubble_ctrl_all: got %h expected 0", ctrl_obs()); end
        n_checks++; if (bus.bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL bubble_cnt_1: got %0d expected 1", bus.bubble_cnt); end
        n_checks++; if (bus.flush_cnt !== 4'd0) begin n_fail++; $display("FAIL bubble_flush_cnt: got %0d expected 0", bus.flush_cnt); end
        bus.hazard_detected = 1'b0;
        step();
        n_checks++; if ({bus.dest_EXE, bus.WB_EN_EXE, bus.MEM_R_EN_EXE, bus.EXE_CMD_out} !== {5'd7, 1'b1, 1'b1, 4'h5})
            begin n_fail++; $display("FAIL after_bubble_load: got %0d/%b/%b/%h expected 7/1/1/5", bus.dest_EXE, bus.WB_EN_EXE, bus.MEM_R_EN_EXE, bus.EXE_CMD_out); end
        n_checks++; if (bus.bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL after_bubble_cnt: got %0d expected 1", bus.bubble_cnt); end
    endtask

    task automatic test_freeze_over_hazard();
        drive_load(32'h0000_0300, 32'h0000_9999, 32'h0, 32'h0,
                   5'd1, 5'd1, 5'd9, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        step();
        n_checks++; if (bus.dest_EXE !== 5'd9) begin n_fail++; $display("FAIL pre_freeze_dest: got %0d expected 9", bus.dest_EXE); end
        drive_load(32'h0000_0304, 32'h0000_BBBB, 32'h0, 32'h0,
                   5'd1, 5'd1, 5'd11, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        bus.freeze = 1'b1; bus.hazard_detected = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if ({bus.dest_EXE, bus.WB_EN_EXE, bus.val1_out} !== {5'd9, 1'b1, 32'h0000_9999})
                begin n_fail++; $display("FAIL freeze_hold[%0d]: got %0d/%b/%h expected 9/1/00009999", i, bus.dest_EXE, bus.WB_EN_EXE, bus.val1_out); end
            n_checks++; if (bus.bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL freeze_bubble_cnt[%0d]: got %0d expected 1", i, bus.bubble_cnt); end
        end
        bus.hazard_detected = 1'b0; bus.flush = 1'b1;
        step();
        n_checks++; if ({bus.dest_EXE, bus.flush_cnt} !== {5'd9, 4'd0})
            begin n_fail++; $display("FAIL freeze_over_flush: got %0d/%0d expected 9/0", bus.dest_EXE, bus.flush_cnt); end
        bus.freeze = 1'b0; bus.flush = 1'b0;
        step();
        n_checks++; if (bus.dest_EXE !== 5'd11) begin n_fail++; $display("FAIL unfreeze_dest: got %0d expected 11", bus.dest_EXE); end
    endtask

    task automatic test_flush_vs_hazard();
        drive_load(32'h0000_0400, 32'h1, 32'h2, 32'h3,
                   5'd8, 5'd10, 5'd12, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        bus.flush = 1'b1; bus.hazard_detected = 1'b1;
        step();
        n_checks++; if (ctrl_obs() !== 26'd0) begin n_fail++; $display("FAIL flush_ctrl: got %h expected 0", ctrl_obs()); end
        n_checks++; if ({bus.flush_cnt, bus.bubble_cnt} !== {4'd1, 4'd1})
            begin n_fail++; $display("FAIL flush_hazard_cnts: got %0d/%0d expected 1/1", bus.flush_cnt, bus.bubble_cnt); end
        bus.hazard_detected = 1'b0;
        step();
        n_checks++; if ({bus.WB_EN_EXE, bus.MEM_W_EN_EXE, bus.flush_cnt} !== {1'b0, 1'b0, 4'd2})
            begin n_fail++; $display("FAIL flush_only: got %b/%b/%0d expected 0/0/2", bus.WB_EN_EXE, bus.MEM_W_EN_EXE, bus.flush_cnt); end
        bus.flush = 1'b0;
        step();
        n_checks++; if ({bus.dest_EXE, bus.MEM_W_EN_EXE, bus.flush_cnt, bus.bubble_cnt} !== {5'd12, 1'b1, 4'd2, 4'd1})
            begin n_fail++; $display("FAIL after_flush: got %0d/%b/%0d/%0d expected 12/1/2/1", bus.dest_EXE, bus.MEM_W_EN_EXE, bus.flush_cnt, bus.bubble_cnt); end
    endtask

    task automatic test_reset_mid_freeze();
        bus.freeze = 1'b1; rst = 1'b0;
        step();
        n_checks++; if ({ctrl_obs(), data_obs()} !== 154'd0) begin n_fail++; $display("FAIL reset_in_freeze_regs: got %h expected 0", {ctrl_obs(), data_obs()}); end
        n_checks++; if ({bus.bubble_cnt, bus.flush_cnt} !== 8'd0)
            begin n_fail++; $display("FAIL reset_in_freeze_cnts: got %0d/%0d expected 0/0", bus.bubble_cnt, bus.flush_cnt); end
        rst = 1'b1; bus.freeze = 1'b0;
        step();
        n_checks++; if (bus.dest_EXE !== 5'd12) begin n_fail++; $display("FAIL post_reset_load: got %0d expected 12", bus.dest_EXE); end
    endtask

    task automatic test_saturation();
        bus.hazard_detected = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15) begin
                n_checks++; if (bus.bubble_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d expected 15", bus.bubble_cnt); end
            end
        end
        n_checks++; if ({bus.bubble_cnt, bus.WB_EN_EXE, bus.dest_EXE} !== {4'd15, 1'b0, 5'd0})
            begin n_fail++; $display("FAIL sat_hold: got %0d/%b/%0d expected 15/0/0", bus.bubble_cnt, bus.WB_EN_EXE, bus.dest_EXE); end
        rst = 1'b0;
        step();
        n_checks++; if (bus.bubble_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_reset: got %0d expected 0", bus.bubble_cnt); end
        rst = 1'b1;
        step();
        n_checks++; if (bus.bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL sat_restart: got %0d expected 1", bus.bubble_cnt); end
        bus.hazard_detected = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.freeze = 1'b0; bus.flush = 1'b0; bus.hazard_detected = 1'b0;
        drive_load('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        test_reset();
        test_normal_load();
        test_back_to_back();
        test_load_use_bubble();
        test_freeze_over_hazard();
        test_flush_vs_hazard();
        test_reset_mid_freeze();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
